// File: rtl/counter_arbiter_pkg.sv
// counter_arbiter_pkg
//   Shared definitions for the two-requester counter arbiter: command
//   encodings, FSM state type and the default counter width.
package counter_arbiter_pkg;

    localparam int unsigned CNT_WIDTH_DFLT = 8;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_UP   = 2'b01,
        CMD_DN   = 2'b10,
        CMD_LOAD = 2'b11
    } cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/counter_arbiter_rr_arb2.sv
// rr_arb2
//   Two-input round-robin arbiter with a last-granted pointer.
//   Ports:
//     i_clk    clock
//     i_rst_n  synchronous active-low reset (pointer -> 1, so input 0 wins
//              the first tie)
//     i_req    request vector
//     i_upd    commit the current grant into the pointer
//     o_gnt    one-hot grant (combinational), zero when no request
module rr_arb2
    import counter_arbiter_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_comb begin
        o_gnt = i_req;
        // Tie: favour the requester that was not granted last.
        if (i_req == 2'b11) begin
            o_gnt = r_last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= 1'b1;
        end else if (i_upd && (o_gnt != 2'b00)) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Shared up/down/load counter serving two requesters through a
//   round-robin arbiter. One command is issued per IDLE->EXEC->IDLE pass.
//   Ports:
//     clk          system clock (rising edge)
//     rst          synchronous active-low reset
//     req0/req1    requests, held until the matching grant
//     cmd0/cmd1    commands (NOP/UP/DN/LOAD)
//     a/b          load data for requester 0/1
//     gnt0/gnt1    one-cycle grant pulse in the EXEC cycle
//     q            counter value
//     busy         high in EXEC
//     ovf          pulse with the grant on UP at max or DN at zero
//   Build option: CNT_SAT_EN -- saturate instead of wrapping (ovf still pulses).
//
//   state | meaning
//   IDLE  | waiting; a sampled request latches winner, command and data
//   EXEC  | grant/busy asserted; counter updated on the edge leaving
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_WIDTH_DFLT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       cmd0,
    input  logic [1:0]       cmd1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             ovf
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_win;
    cmd_e             r_cmd;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic [1:0]       w_arb_gnt;
    logic             w_latch;
    logic             w_at_max;
    logic             w_at_min;

    assign w_latch  = (r_state == ST_IDLE) && (req0 || req1);
    assign w_at_max = (r_q == {WIDTH{1'b1}});
    assign w_at_min = (r_q == '0);

    // Pointer advances at the latching edge; no arbitration happens in EXEC,
    // so this is indistinguishable from advancing on the grant itself.
    rr_arb2 u_arb (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_req   ({req1, req0}),
        .i_upd   (w_latch),
        .o_gnt   (w_arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        busy        = 1'b0;
        ovf         = 1'b0;
        w_q_nxt     = r_q;
        unique case (r_state)
            ST_IDLE: begin
                if (w_latch) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_IDLE;
                busy        = 1'b1;
                gnt0        = ~r_win;
                gnt1        = r_win;
                unique case (r_cmd)
                    CMD_UP: begin
                        ovf = w_at_max;
`ifdef CNT_SAT_EN
                        w_q_nxt = w_at_max ? r_q : r_q + WIDTH'(1);
`else
                        w_q_nxt = r_q + WIDTH'(1);
`endif
                    end
                    CMD_DN: begin
                        ovf = w_at_min;
`ifdef CNT_SAT_EN
                        w_q_nxt = w_at_min ? r_q : r_q - WIDTH'(1);
`else
                        w_q_nxt = r_q - WIDTH'(1);
`endif
                    end
                    CMD_LOAD: w_q_nxt = r_data;
                    default:  w_q_nxt = r_q;
                endcase
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q    <= '0;
            r_win  <= 1'b0;
            r_cmd  <= CMD_NOP;
            r_data <= '0;
        end else begin
            r_q <= w_q_nxt;
            if (w_latch) begin
                r_win  <= w_arb_gnt[1];
                r_cmd  <= w_arb_gnt[1] ? cmd_e'(cmd1) : cmd_e'(cmd0);
                r_data <= w_arb_gnt[1] ? b : a;
            end
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter
//   Directed bench for counter_arbiter with hand-computed expectations.
module tb_counter_arbiter;
    import counter_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [1:0] cmd0 = 2'b00, cmd1 = 2'b00;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       gnt0, gnt1, busy, ovf;
    logic [7:0] q;

    int n_cmp = 0;
    int n_err = 0;

`ifdef CNT_SAT_EN
    localparam logic [7:0] EXP_UP_MAX = 8'hFF;
    localparam logic [7:0] EXP_DN_MIN = 8'h00;
`else
    localparam logic [7:0] EXP_UP_MAX = 8'h00;
    localparam logic [7:0] EXP_DN_MIN = 8'hFF;
`endif

    counter_arbiter #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .cmd0 (cmd0),
        .cmd1 (cmd1),
        .a    (a),
        .b    (b),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .q    (q),
        .busy (busy),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called just after a negedge with the DUT in IDLE. Issues one command,
    // checks the grant cycle, drops requests on the edge after the grant and
    // checks the resulting counter value.
    task automatic run_cmd(input string tag, input logic r0, input logic r1,
                           input logic [1:0] c0, input logic [1:0] c1,
                           input logic [7:0] da, input logic [7:0] db,
                           input logic eg0, input logic eg1, input logic eovf,
                           input logic [7:0] eq);
        req0 = r0; req1 = r1; cmd0 = c0; cmd1 = c1; a = da; b = db;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(eg0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(eg1));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        chk({tag, ".ovf"},  32'(ovf),  32'(eovf));
        @(posedge clk);
        #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk({tag, ".q"},     32'(q), 32'(eq));
        chk({tag, ".idle"},  32'({busy, gnt0, gnt1, ovf}), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.q",    32'(q),    32'h00);
        chk("rst.gnt",  32'({gnt0, gnt1}), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.ovf",  32'(ovf),  32'd0);
        rst = 1'b1;

        run_cmd("load_a5", 1, 0, CMD_LOAD, CMD_NOP, 8'hA5, 8'h00, 1, 0, 0, 8'hA5);
        // No re-issue once the request has been dropped.
        @(negedge clk);
        chk("no_dbl.busy", 32'(busy), 32'd0);

        run_cmd("load_10", 0, 1, CMD_NOP, CMD_LOAD, 8'h00, 8'h10, 0, 1, 0, 8'h10);

        // Both held: alternate 0,1,0,1 at one command per two cycles.
        req0 = 1'b1; req1 = 1'b1; cmd0 = CMD_UP; cmd1 = CMD_DN;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("tie%0d.gnt", i), 32'({gnt1, gnt0}), (i % 2 == 0) ? 32'b01 : 32'b10);
            chk($sformatf("tie%0d.ovf", i), 32'(ovf), 32'd0);
            if (i == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("tie%0d.q", i), 32'(q), (i % 2 == 0) ? 32'h11 : 32'h10);
        end

        run_cmd("load_ff", 1, 0, CMD_LOAD, CMD_NOP, 8'hFF, 8'h00, 1, 0, 0, 8'hFF);
        run_cmd("up_max",  0, 1, CMD_NOP, CMD_UP, 8'h00, 8'h00, 0, 1, 1, EXP_UP_MAX);
        run_cmd("load_00", 0, 1, CMD_NOP, CMD_LOAD, 8'h00, 8'h00, 0, 1, 0, 8'h00);
        run_cmd("dn_min",  1, 0, CMD_DN, CMD_NOP, 8'h00, 8'h00, 1, 0, 1, EXP_DN_MIN);
        run_cmd("nop",     1, 0, CMD_NOP, CMD_NOP, 8'h77, 8'h00, 1, 0, 0, EXP_DN_MIN);
        run_cmd("tie_nop", 1, 1, CMD_UP, CMD_LOAD, 8'h00, 8'h5A, 0, 1, 0, 8'h5A);

        // Reset in the EXEC cycle of a load aborts it.
        run_cmd("load_07", 1, 0, CMD_LOAD, CMD_NOP, 8'h07, 8'h00, 1, 0, 0, 8'h07);
        req0 = 1'b1; cmd0 = CMD_LOAD; a = 8'h3C;
        @(posedge clk);
        @(negedge clk);
        chk("rexec.gnt0", 32'(gnt0), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rexec.q",   32'(q), 32'h00);
        chk("rexec.out", 32'({gnt0, gnt1, busy, ovf}), 32'd0);
        req0 = 1'b0;
        rst  = 1'b1;
        @(negedge clk);
        chk("rexec.after_q", 32'(q), 32'h00);

        // Pointer is back to its reset value: requester 0 wins the tie.
        run_cmd("post_rst_tie", 1, 1, CMD_UP, CMD_DN, 8'h00, 8'h00, 1, 0, 0, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
